// File: rtl/fifo_prefetch_pkg.sv
// Shared constants for the FIFO read-data prefetch stage.
// FIFO_PREFETCH_MEM_LAT2_EN selects the registered-output memory (MEM_LAT 2, BUF_DEPTH 3).
package fifo_prefetch_pkg;

`ifdef FIFO_PREFETCH_MEM_LAT2_EN
  localparam int unsigned MEM_LAT   = 2;
  localparam int unsigned BUF_DEPTH = 3;
`else
  localparam int unsigned MEM_LAT   = 1;
  localparam int unsigned BUF_DEPTH = 2;
`endif

  // out_level is 2 bits in both builds; occupancy math gets one bit of headroom
  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned PTR_W   = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W   = 3;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [OCC_W-1:0]   occ_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rdata_prefetch_if.sv
// Controller/memory side and consumer side signals of the prefetch stage.
interface fifo_rdata_prefetch_if
  import fifo_prefetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_rd_op;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  level_t                out_level;

  modport master (
    input  fifo_empty, mem_rdata, out_ready,
    output fifo_rd_op, out_valid, out_data, out_level
  );

  modport slave (
    output fifo_empty, mem_rdata, out_ready,
    input  fifo_rd_op, out_valid, out_data, out_level
  );
endinterface

// File: rtl/prefetch_skid_buf.sv
// Circular skid buffer holding captured read words; head word is always presented.
module prefetch_skid_buf
  import fifo_prefetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head_data,
  output level_t                count
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t head;
  ptr_t tail;
  logic pop_ok_c;

  // a pop against an empty buffer is ignored
  assign pop_ok_c = pop & (count != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= ptr_inc(tail);
      end
      if (pop_ok_c) head <= ptr_inc(head);
      count <= count + LEVEL_W'(push) - LEVEL_W'(pop_ok_c);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rdata_prefetch.sv
// Read-side prefetch stage: issues FIFO reads against buffer credit and captures memory data.
// FIFO_PREFETCH_MEM_LAT2_EN (via fifo_prefetch_pkg) selects MEM_LAT 2 / BUF_DEPTH 3.
module fifo_rdata_prefetch
  import fifo_prefetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  fifo_rdata_prefetch_if.master bus
);

  logic [MEM_LAT-1:0] vld_sr;
  level_t             level;
  occ_t               inflight_c;
  occ_t               occ_c;
  logic               pop_c;
  logic               push_c;
  logic               rd_op_c;
  logic [DATA_WIDTH-1:0] head_data;

  // number of reads issued whose data has not yet been captured
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < MEM_LAT; i++) begin
      inflight_c = inflight_c + OCC_W'(vld_sr[i]);
    end
  end

  assign pop_c  = bus.out_valid & bus.out_ready;
  assign push_c = vld_sr[MEM_LAT-1];
  assign occ_c  = OCC_W'(level) + inflight_c;

  // a read is only issued when its data is guaranteed a free buffer slot on return
  assign rd_op_c = reset_n & ~clr & ~bus.fifo_empty
                 & ((occ_c - OCC_W'(pop_c)) < OCC_W'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_sr <= '0;
    end else if (clr) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= MEM_LAT'({vld_sr, rd_op_c});
    end
  end

  prefetch_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .push      (push_c),
    .pop       (pop_c),
    .wdata     (bus.mem_rdata),
    .head_data (head_data),
    .count     (level)
  );

  assign bus.fifo_rd_op = rd_op_c;
  assign bus.out_valid  = (level != '0);
  assign bus.out_data   = head_data;
  assign bus.out_level  = level;

endmodule

// File: tb/tb_fifo_rdata_prefetch.sv
// Bench for fifo_rdata_prefetch: controller/memory emulation plus a queue-level model of the stage.
module tb_fifo_rdata_prefetch;
  import fifo_prefetch_pkg::*;

`ifdef FIFO_PREFETCH_MEM_LAT2_EN
  localparam int EXP_MEM_LAT = 2;
  localparam int EXP_DEPTH   = 3;
  localparam int EXP_FIRST   = 3;
`else
  localparam int EXP_MEM_LAT = 1;
  localparam int EXP_DEPTH   = 2;
  localparam int EXP_FIRST   = 2;
`endif

  logic clk;
  logic reset_n;
  logic clr;

  fifo_rdata_prefetch_if #(.DATA_WIDTH(32)) bus ();

  fifo_rdata_prefetch #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] q[$];
  logic [31:0] pipe [EXP_MEM_LAT];
  logic [31:0] expq[$];
  logic [31:0] infl_w[$];
  int          infl_t[$];
  logic [31:0] rx[$];

  int rd_cnt, v_cnt, first_rd, first_v, first_pop, last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; v_cnt = 0; first_rd = -1; first_v = -1; first_pop = -1; last_pop = -1;
    rx.delete();
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) q.push_back(base + 32'(i));
    bus.fifo_empty = 1'b0;
  endtask

  // one clock: check issue before the edge, advance controller/memory/model, check outputs after
  task automatic step();
    bit pop_m, rd_m, rd_a;
    logic [31:0] w, tmp;
    #1;
    pop_m = (expq.size() != 0) && bus.out_ready;
    rd_m  = reset_n && !clr && (q.size() != 0) &&
            ((expq.size() + infl_w.size() - int'(pop_m)) < EXP_DEPTH);
    rd_a  = bus.fifo_rd_op;
    chk("rd_op", 32'(rd_a), 32'(rd_m));
    if (rd_a) begin rd_cnt++; if (first_rd < 0) first_rd = cyc; end
    if (bus.out_valid) begin v_cnt++; if (first_v < 0) first_v = cyc; end
    if (bus.out_valid && bus.out_ready) begin
      rx.push_back(bus.out_data);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end

    @(posedge clk);
    cyc++;
    #1;
    w = 32'hDEAD_0000 | 32'(cyc);
    if (rd_a && q.size() != 0) w = q.pop_front();
    if (!reset_n || clr) q.delete();
    for (int i = EXP_MEM_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = w;
    bus.mem_rdata  = pipe[EXP_MEM_LAT-1];
    bus.fifo_empty = (q.size() == 0);

    if (!reset_n || clr) begin
      expq.delete(); infl_w.delete(); infl_t.delete();
    end else begin
      if (pop_m) tmp = expq.pop_front();
      foreach (infl_t[i]) infl_t[i]--;
      if (infl_t.size() != 0 && infl_t[0] == 0) begin
        expq.push_back(infl_w.pop_front());
        tmp = 32'(infl_t.pop_front());
      end
      if (rd_m) begin
        infl_w.push_back(rd_a ? w : 32'hBAD0_BAD0);
        infl_t.push_back(EXP_MEM_LAT);
      end
    end

    chk("out_valid", 32'(bus.out_valid), 32'(expq.size() != 0));
    chk("out_level", 32'(bus.out_level), 32'(expq.size()));
    if (expq.size() != 0) chk("out_data", bus.out_data, expq[0]);
    else if (!reset_n) chk("out_data_rst", bus.out_data, 32'h0);
    chk("level_bound", 32'(bus.out_level <= 2'(EXP_DEPTH)), 32'h1);
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0;
    bus.fifo_empty = 1'b1; bus.mem_rdata = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < EXP_MEM_LAT; i++) pipe[i] = '0;
    clear_stats();

    step(); step();
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_level", 32'(bus.out_level), 32'h0);
    chk("rst_data", bus.out_data, 32'h0);
    chk("rst_rd_op", 32'(bus.fifo_rd_op), 32'h0);
    reset_n = 1'b1;

    // four words streamed with the consumer always ready
    clear_stats();
    bus.out_ready = 1'b1;
    push_words(32'hA0, 4);
    repeat (12) step();
    chk("s1_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("s1_latency", 32'(first_v - first_rd), 32'(EXP_FIRST));
    chk("s1_valid_cycles", 32'(v_cnt), 32'd4);
    chk("s1_contig", 32'(last_pop - first_pop), 32'd3);
    chk("s1_rx_n", 32'(rx.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < rx.size()) chk("s1_data", rx[i], 32'hA0 + 32'(i));

    // consumer stalled: issue stops at buffer depth, then drains in order
    clear_stats();
    bus.out_ready = 1'b0;
    push_words(32'hB0, 8);
    repeat (10) step();
    chk("s2_rd_cnt", 32'(rd_cnt), 32'(EXP_DEPTH));
    chk("s2_level", 32'(bus.out_level), 32'(EXP_DEPTH));
    chk("s2_rd_stall", 32'(bus.fifo_rd_op), 32'h0);
    clear_stats();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && rx.size() < 8; k++) step();
    chk("s2_rx_n", 32'(rx.size()), 32'd8);
    chk("s2_resume", 32'(first_rd - first_pop), 32'd0);
    chk("s2_contig", 32'(last_pop - first_pop), 32'd7);
    for (int i = 0; i < 8; i++) if (i < rx.size()) chk("s2_data", rx[i], 32'hB0 + 32'(i));

    // ready toggling every cycle
    clear_stats();
    push_words(32'hC0, 16);
    for (int k = 0; k < 120 && rx.size() < 16; k++) begin
      bus.out_ready = ~bus.out_ready;
      step();
    end
    chk("s3_rx_n", 32'(rx.size()), 32'd16);
    for (int i = 0; i < 16; i++) if (i < rx.size()) chk("s3_data", rx[i], 32'hC0 + 32'(i));
    bus.out_ready = 1'b1;
    repeat (4) step();

    // clr one cycle after a read issue discards the in-flight word
    clear_stats();
    bus.out_ready = 1'b0;
    push_words(32'hD0, 3);
    step();
    chk("s4_issue", 32'(rd_cnt), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("s4_valid", 32'(bus.out_valid), 32'h0);
    chk("s4_level", 32'(bus.out_level), 32'h0);
    bus.out_ready = 1'b1;
    repeat (8) step();
    chk("s4_rx_n", 32'(rx.size()), 32'd0);
    chk("s4_valid_late", 32'(bus.out_valid), 32'h0);

    // reset mid-stream with a full buffer
    clear_stats();
    bus.out_ready = 1'b0;
    push_words(32'hE0, 4);
    repeat (6) step();
    chk("s5_level_pre", 32'(bus.out_level), 32'(EXP_DEPTH));
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("s5_valid", 32'(bus.out_valid), 32'h0);
    chk("s5_level", 32'(bus.out_level), 32'h0);
    chk("s5_data", bus.out_data, 32'h0);
    chk("s5_rd_op", 32'(bus.fifo_rd_op), 32'h0);
    step();
    chk("s5_rd_op_hold", 32'(bus.fifo_rd_op), 32'h0);
    reset_n = 1'b1;
    repeat (4) step();
    chk("s5_valid_after", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rdata_prefetch.md
# fifo_rdata_prefetch

Read-side output stage for the single-clock generic FIFO controller and its 1r1w compiled memory. It watches the controller's `empty`, drives the controller's `rd_op` (which also serves as the memory read enable), and captures `mem_rdata` after the fixed memory read latency. Captured words go into a small skid buffer, so the consumer sees a registered valid/ready stream with no combinational path to the memory. It sits directly downstream of the pointer controller and memory.

## Interface
Parameters:
- DATA_WIDTH, 32, width of memory read data and of out_data

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- clr  in  1  synchronous flush; asserted in the same cycle as the controller's clr
- fifo_empty  in  1  controller empty flag
- fifo_rd_op  out  1  read request to the controller; also the memory read enable for the current rd_addr
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LAT cycles after fifo_rd_op
- out_valid  out  1  head word available
- out_ready  in  1  consumer accepts the head word
- out_data  out  DATA_WIDTH  head word
- out_level  out  2  occupied skid-buffer entries, 0..BUF_DEPTH

## Operation
- Constants: MEM_LAT = 1 and BUF_DEPTH = 2 by default, or MEM_LAT = 2 and BUF_DEPTH = 3 with the macro (see Configuration).
- Credit: `occ = out_level + inflight`, where inflight is the number of reads issued whose data has not yet been captured.
- Issue rule: `fifo_rd_op = reset_n & !clr & !fifo_empty & (occ - pop < BUF_DEPTH)`, where `pop = out_valid & out_ready`. The buffer therefore never overflows and never needs backpressure on returned data.
- Inflight tracking: a MEM_LAT-deep valid shift register. Stage 0 loads fifo_rd_op. The last stage asserted means mem_rdata is written into the buffer tail this cycle.
- Buffer: circular, BUF_DEPTH entries, with head/tail pointers and a count.
  - Push when the last valid stage is set; pop when out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap from BUF_DEPTH-1 to 0.
- Outputs: out_valid = (count != 0); out_data = buf[head]; out_level = count.
- out_ready while out_valid is low is ignored.
- clr: clears the inflight shift register, count and pointers in the same cycle, and forces fifo_rd_op low. Read data already in the memory pipeline is discarded.
- No error outputs. Underflow is impossible because reads are gated by fifo_empty; overflow is impossible by the credit rule.

## Timing
- Reset (reset_n low at a clk edge): out_valid 0, out_data 0, out_level 0, inflight 0. fifo_rd_op is 0 combinationally throughout reset.
- fifo_rd_op is combinational from fifo_empty, out_ready and registered state, in the same cycle the controller samples it.
- First-word latency, with fifo_empty low in cycle T and the buffer empty:
  - fifo_rd_op asserts in T.
  - mem_rdata is captured at the end of T+MEM_LAT.
  - out_valid rises in T+MEM_LAT+1.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and out_ready stays high.
- With out_ready low, reads continue until occ reaches BUF_DEPTH, then stop. They resume in the cycle the first pop occurs.
- Reset or clr mid-stream: the next cycle shows out_valid 0 and out_level 0, and nothing captured afterwards comes from pre-clr reads.

## Configuration
- FIFO_PREFETCH_MEM_LAT2_EN
  - Defined: the memory has registered outputs; MEM_LAT = 2, BUF_DEPTH = 3, and the inflight shift register is 2 deep.
  - Undefined: MEM_LAT = 1 and BUF_DEPTH = 2.
  - out_level stays 2 bits in both builds.

## Structure
- Package fifo_prefetch_pkg holds:
  - MEM_LAT and BUF_DEPTH, selected under the macro.
  - The count and pointer width localparams.
- Sub-module prefetch_skid_buf holds the circular buffer: push/pop, data in, head data out, count.
- The top level holds the issue logic and the inflight shift register.

## Test plan
- Reset, then write 4 words (0xA0..0xA3) through the controller with out_ready=1 → fifo_rd_op in 4 consecutive cycles; out_valid high for 4 consecutive cycles starting MEM_LAT+1 after the first read; data arrives in order.
- out_ready held 0 with 8 words stored → exactly BUF_DEPTH reads issued, then fifo_rd_op stays 0 and out_level = BUF_DEPTH. Raising out_ready drains all 8 words in order with no gaps after the first.
- Toggle out_ready every cycle over 16 words → no word lost or duplicated, and out_level never exceeds BUF_DEPTH.
- Pulse clr one cycle after a read issue with 3 words in the FIFO → the next cycle shows out_valid 0 and out_level 0; the in-flight word is never presented.
- Apply reset_n low mid-stream with out_level = 2 → the next cycle shows all outputs at their reset values and fifo_rd_op 0 while reset is held.
- Build with FIFO_PREFETCH_MEM_LAT2_EN and rerun the first two scenarios → first-word latency is 3 cycles and the stall point is BUF_DEPTH = 3.
